// File: rtl/cpu_bus_map_pkg.sv
// Address map, source selection and shared constants for the CPU bus responder.
package cpu_bus_map_pkg;

  localparam logic [15:0] RAM_LIMIT          = 16'h2000;
  localparam logic [15:0] PAD0_ADDR_DEFAULT  = 16'h4016;
  localparam logic [15:0] PAD1_ADDR_DEFAULT  = 16'h4017;

  typedef enum logic [2:0] {
    SRC_RAM  = 3'd0,
    SRC_PAD0 = 3'd1,
    SRC_PAD1 = 3'd2,
    SRC_EXT  = 3'd3,
    SRC_OPEN = 3'd4
  } bus_src_t;

  // Internal sources take priority; external data only counts when a device claims the cycle.
  function automatic bus_src_t select_src(input logic ram_hit,
                                          input logic pad0_hit,
                                          input logic pad1_hit,
                                          input logic ext_hit);
    bus_src_t src;
    if (ram_hit) begin
      src = SRC_RAM;
    end else if (pad0_hit) begin
      src = SRC_PAD0;
    end else if (pad1_hit) begin
      src = SRC_PAD1;
    end else if (ext_hit) begin
      src = SRC_EXT;
    end else begin
      src = SRC_OPEN;
    end
    return src;
  endfunction

endpackage

// File: rtl/cpu_bus_target_if.sv
// CPU-side bus bundle: the core (master) drives address/data/phi2, the responder (slave) answers.
interface cpu_bus_target_if;
  logic [15:0] I_addr;
  logic [7:0]  I_wr_data;
  logic        I_rdwr;
  logic        I_phy2;
  logic [7:0]  O_rd_data;
  logic        O_ext_sel;
  logic [7:0]  I_ext_rd_data;
  logic        I_ext_hit;

  modport master (
    output I_addr, I_wr_data, I_rdwr, I_phy2, I_ext_rd_data, I_ext_hit,
    input  O_rd_data, O_ext_sel
  );

  modport slave (
    input  I_addr, I_wr_data, I_rdwr, I_phy2, I_ext_rd_data, I_ext_hit,
    output O_rd_data, O_ext_sel
  );
endinterface

// File: rtl/cpu_bus_target_pad_shifter.sv
// Controller serial port: parallel reload while strobed, shift-right with 1-fill on reads.
module pad_shifter (
  input  logic       clock,
  input  logic       reset,
  input  logic       strobe,
  input  logic [7:0] load_data,
  input  logic       shift_en,
  output logic       serial_out
);

  logic [7:0] sh_r;

  // Strobe dominates; after eight shifts only the filled-in ones remain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_r <= 8'hFF;
    end else if (strobe) begin
      sh_r <= load_data;
    end else if (shift_en) begin
      sh_r <= {1'b1, sh_r[7:1]};
    end
  end

  assign serial_out = sh_r[0];

endmodule

// File: rtl/cpu_bus_target.sv
// Responder end of the CPU bus: mirrored work RAM, two controller ports, external
// select and an open-bus latch; bus cycles complete on the falling edge of phi2.
module cpu_bus_target
  import cpu_bus_map_pkg::*;
#(
  parameter int          RAM_ADDR_BITS = 11,
  parameter logic [15:0] PAD0_ADDR     = PAD0_ADDR_DEFAULT,
  parameter logic [15:0] PAD1_ADDR     = PAD1_ADDR_DEFAULT
) (
  input  logic                   I_clock,
  input  logic                   I_reset,
  cpu_bus_target_if.slave        bus,
  input  logic [7:0]             I_pad0,
  input  logic [7:0]             I_pad1,
  output logic                   O_pad_strobe
);

  localparam int RAM_WORDS = 32'd1 << RAM_ADDR_BITS;

  logic                     last_phy2_r;
  logic                     bus_end_s;
  logic                     ram_hit_s;
  logic                     pad0_hit_s;
  logic                     pad1_hit_s;
  logic [RAM_ADDR_BITS-1:0] ram_idx_s;
  bus_src_t                 src_s;
  logic [7:0]               rd_next_s;
  logic [7:0]               rd_data_r;
  logic [7:0]               open_bus_r;
  logic                     strobe_r;
  logic                     sh0_bit_s;
  logic                     sh1_bit_s;
  logic                     sh0_shift_s;
  logic                     sh1_shift_s;
  logic [7:0]               ram_r [0:RAM_WORDS-1];

  assign bus_end_s  = last_phy2_r & ~bus.I_phy2;
  assign ram_hit_s  = (bus.I_addr < RAM_LIMIT);
  assign pad0_hit_s = (bus.I_addr == PAD0_ADDR);
  assign pad1_hit_s = (bus.I_addr == PAD1_ADDR);
  assign ram_idx_s  = bus.I_addr[RAM_ADDR_BITS-1:0];
  assign src_s      = select_src(ram_hit_s, pad0_hit_s, pad1_hit_s, bus.I_ext_hit);

  // A read consumes a pad bit only when the port is not being held in reload.
  assign sh0_shift_s = bus_end_s & bus.I_rdwr & pad0_hit_s & ~strobe_r;
  assign sh1_shift_s = bus_end_s & bus.I_rdwr & pad1_hit_s & ~strobe_r;

  // Read-data source mux feeding the registered read port.
  always_comb begin
    rd_next_s = open_bus_r;
    case (src_s)
      SRC_RAM:  rd_next_s = ram_r[ram_idx_s];
      SRC_PAD0: rd_next_s = {open_bus_r[7:5], 4'b0000, sh0_bit_s};
      SRC_PAD1: rd_next_s = {open_bus_r[7:5], 4'b0000, sh1_bit_s};
      SRC_EXT:  rd_next_s = bus.I_ext_rd_data;
      SRC_OPEN: rd_next_s = open_bus_r;
      default:  rd_next_s = open_bus_r;
    endcase
  end

  // Phi2 edge tracking, read-data register, open-bus latch and strobe register.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      last_phy2_r <= 1'b0;
      rd_data_r   <= 8'h00;
      open_bus_r  <= 8'h00;
      strobe_r    <= 1'b0;
    end else begin
      last_phy2_r <= bus.I_phy2;
      if (bus.I_phy2) begin
        rd_data_r <= rd_next_s;
      end
      if (bus_end_s) begin
        open_bus_r <= bus.I_rdwr ? rd_data_r : bus.I_wr_data;
        if (!bus.I_rdwr && pad0_hit_s) begin
          strobe_r <= bus.I_wr_data[0];
        end
      end
    end
  end

  // Work-RAM write port; contents are deliberately left untouched by reset.
  always_ff @(posedge I_clock) begin
    if (bus_end_s && !bus.I_rdwr && ram_hit_s && !I_reset) begin
      ram_r[ram_idx_s] <= bus.I_wr_data;
    end
  end

  pad_shifter u_pad0 (
    .clock      (I_clock),
    .reset      (I_reset),
    .strobe     (strobe_r),
    .load_data  (I_pad0),
    .shift_en   (sh0_shift_s),
    .serial_out (sh0_bit_s)
  );

  pad_shifter u_pad1 (
    .clock      (I_clock),
    .reset      (I_reset),
    .strobe     (strobe_r),
    .load_data  (I_pad1),
    .shift_en   (sh1_shift_s),
    .serial_out (sh1_bit_s)
  );

  // $4017 writes belong to the APU frame counter, so ext_sel stays low there too.
  assign bus.O_ext_sel = ~(ram_hit_s | pad0_hit_s | pad1_hit_s);
  assign bus.O_rd_data = rd_data_r;
  assign O_pad_strobe  = strobe_r;

endmodule
